// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Shares single-ported dmem between the CPU memory stage and one
//            AUX requester, with bounded AUX starvation.
// Revision : 1.0
// ============================================================================
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_stall_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              aux_req_i,
  input  logic              aux_we_i,
  input  logic [ADDR_W-1:0] aux_addr_i,
  input  logic [DATA_W-1:0] aux_wdata_i,
  output logic              aux_gnt_o,
  output logic              aux_rvalid_o,
  output logic [DATA_W-1:0] aux_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wren_o,
  input  logic [DATA_W-1:0] mem_q_i
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] C_MAX_WAIT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_AUX} owner_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_AUX} rd_tag_e;

  owner_e            owner;
  logic              force_aux;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  rd_tag_e           rd_tag_q, rd_tag_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DATA_W-1:0] last_wdata_q, last_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;

  always_comb begin
    force_aux = aux_req_i && (wait_cnt_q == C_MAX_WAIT);
    if (force_aux)      owner = OWN_AUX;
    else if (cpu_req_i) owner = OWN_CPU;
    else if (aux_req_i) owner = OWN_AUX;
    else                owner = OWN_IDLE;
  end

  // Bus drive; an idle bus keeps presenting the last CPU address/data.
  always_comb begin
    mem_addr_o   = last_addr_q;
    mem_wdata_o  = last_wdata_q;
    mem_wren_o   = 1'b0;
    aux_gnt_o    = 1'b0;
    cpu_stall_o  = force_aux && cpu_req_i;
    last_addr_d  = last_addr_q;
    last_wdata_d = last_wdata_q;
    rd_tag_d     = TAG_NONE;
    case (owner)
      OWN_CPU: begin
        mem_addr_o   = cpu_addr_i;
        mem_wdata_o  = cpu_wdata_i;
        mem_wren_o   = cpu_we_i;
        last_addr_d  = cpu_addr_i;
        last_wdata_d = cpu_wdata_i;
        if (!cpu_we_i) rd_tag_d = TAG_CPU;
      end
      OWN_AUX: begin
        mem_addr_o  = aux_addr_i;
        mem_wdata_o = aux_wdata_i;
        mem_wren_o  = aux_we_i;
        aux_gnt_o   = 1'b1;
        if (!aux_we_i) rd_tag_d = TAG_AUX;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_wren_o  = 1'b0;
      aux_gnt_o   = 1'b0;
      cpu_stall_o = 1'b0;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((owner == OWN_AUX) || !aux_req_i) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != C_MAX_WAIT) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Returning read data passes straight through; the register holds it after.
  always_comb begin
    aux_rvalid_o = (rd_tag_q == TAG_AUX);
    cpu_rdata_d  = (rd_tag_q == TAG_CPU) ? mem_q_i : cpu_rdata_q;
    aux_rdata_d  = (rd_tag_q == TAG_AUX) ? mem_q_i : aux_rdata_q;
    cpu_rdata_o  = cpu_rdata_d;
    aux_rdata_o  = aux_rdata_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q   <= '0;
      rd_tag_q     <= TAG_NONE;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
      cpu_rdata_q  <= '0;
      aux_rdata_q  <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      rd_tag_q     <= rd_tag_d;
      last_addr_q  <= last_addr_d;
      last_wdata_q <= last_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      aux_rdata_q  <= aux_rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Purpose  : Directed and randomized checks of dmem_port_arbiter against a
//            cycle-level reference of the arbitration rules.
// Revision : 1.0
// ============================================================================
module tb_dmem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          aux_req = 1'b0, aux_we = 1'b0;
  logic [AW-1:0] aux_addr = '0;
  logic [DW-1:0] aux_wdata = '0;
  logic          aux_gnt, aux_rvalid;
  logic [DW-1:0] aux_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic [DW-1:0] mem_q = '0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_stall_o(cpu_stall), .cpu_rdata_o(cpu_rdata),
    .aux_req_i(aux_req), .aux_we_i(aux_we), .aux_addr_i(aux_addr),
    .aux_wdata_i(aux_wdata), .aux_gnt_o(aux_gnt), .aux_rvalid_o(aux_rvalid),
    .aux_rdata_o(aux_rdata), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_wren_o(mem_wren), .mem_q_i(mem_q)
  );

  // Write-first synchronous single-port dmem with one-cycle read latency.
  logic [DW-1:0] dmem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_wren) begin
      dmem[mem_addr] <= mem_wdata;
      mem_q          <= mem_wdata;
    end else begin
      mem_q <= dmem[mem_addr];
    end
  end

  // Reference state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            lost = 0;
  logic          cpu_pend_v = 1'b0, aux_pend_v = 1'b0;
  logic [DW-1:0] cpu_pend_d = '0, aux_pend_d = '0, cpu_hold = '0, aux_hold = '0;
  logic          cpu_known = 1'b0, cpu_seen = 1'b0, m_gnt = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;

  logic          s_gnt, s_stall, s_wren, s_rvalid;
  logic [DW-1:0] s_cpu_rdata, s_aux_rdata;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample and check at negedge, advance the model, return at posedge+1.
  task automatic step();
    int   own;
    logic frc;
    @(negedge clk);
    s_gnt = aux_gnt; s_stall = cpu_stall; s_wren = mem_wren; s_rvalid = aux_rvalid;
    s_cpu_rdata = cpu_rdata; s_aux_rdata = aux_rdata;
    if (!rst_n) begin
      check("rst_gnt", DW'(aux_gnt), '0);
      check("rst_stall", DW'(cpu_stall), '0);
      check("rst_wren", DW'(mem_wren), '0);
      check("rst_rvalid", DW'(aux_rvalid), '0);
      check("rst_aux_rdata", aux_rdata, '0);
      lost = 0; cpu_pend_v = 1'b0; aux_pend_v = 1'b0; aux_hold = '0;
      cpu_known = 1'b0; cpu_seen = 1'b0; m_gnt = 1'b0;
    end else begin
      frc = aux_req && (lost >= MW);
      own = frc ? 2 : (cpu_req ? 1 : (aux_req ? 2 : 0));
      check("gnt", DW'(aux_gnt), DW'(own == 2));
      check("stall", DW'(cpu_stall), DW'(frc && cpu_req));
      check("wren", DW'(mem_wren), DW'(own == 1 ? cpu_we : (own == 2 ? aux_we : 1'b0)));
      if (own == 1) begin
        check("addr_cpu", DW'(mem_addr), DW'(cpu_addr));
        check("wdata_cpu", mem_wdata, cpu_wdata);
      end else if (own == 2) begin
        check("addr_aux", DW'(mem_addr), DW'(aux_addr));
        check("wdata_aux", mem_wdata, aux_wdata);
      end else if (cpu_seen) begin
        check("addr_idle", DW'(mem_addr), DW'(last_addr));
        check("wdata_idle", mem_wdata, last_wdata);
      end
      if (cpu_pend_v)     check("cpu_rdata", cpu_rdata, cpu_pend_d);
      else if (cpu_known) check("cpu_rdata_hold", cpu_rdata, cpu_hold);
      check("aux_rvalid", DW'(aux_rvalid), DW'(aux_pend_v));
      check("aux_rdata", aux_rdata, aux_pend_v ? aux_pend_d : aux_hold);
      if (cpu_pend_v) begin cpu_hold = cpu_pend_d; cpu_known = 1'b1; end
      if (aux_pend_v) aux_hold = aux_pend_d;
      cpu_pend_v = (own == 1) && !cpu_we; cpu_pend_d = ref_mem[cpu_addr];
      aux_pend_v = (own == 2) && !aux_we; aux_pend_d = ref_mem[aux_addr];
      if (own == 1 && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      if (own == 2 && aux_we) ref_mem[aux_addr] = aux_wdata;
      if (own == 1) begin cpu_seen = 1'b1; last_addr = cpu_addr; last_wdata = cpu_wdata; end
      if (own == 2 || !aux_req) lost = 0;
      else if (lost < MW)       lost = lost + 1;
      m_gnt = (own == 2);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      dmem[i]    = (i * 32'h9E3779B1) + 32'h5A5A0000;
      ref_mem[i] = (i * 32'h9E3779B1) + 32'h5A5A0000;
    end
    dmem[12'h020]    = 32'h12345678;
    ref_mem[12'h020] = 32'h12345678;

    // Reset with requests active: combinational outputs must stay low.
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; aux_req = 1'b1; aux_we = 1'b1;
    step();
    cpu_req = 1'b0; cpu_we = 1'b0; aux_req = 1'b0; aux_we = 1'b0;
    rst_n = 1'b1;

    // 1: reset while an AUX read is in flight.
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 12'h020;
    step();
    check("t1_gnt", DW'(s_gnt), 32'd1);
    rst_n = 1'b0; aux_req = 1'b0;
    step();
    check("t1_rvalid", DW'(s_rvalid), 32'd0);
    check("t1_rdata", s_aux_rdata, 32'd0);
    step();
    rst_n = 1'b1;

    // 2: CPU store then load of the same word.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 32'hDEADBEEF;
    step();
    check("t2_wren_sw", DW'(s_wren), 32'd1);
    check("t2_stall_sw", DW'(s_stall), 32'd0);
    cpu_we = 1'b0; cpu_wdata = 32'h0;
    step();
    check("t2_wren_lw", DW'(s_wren), 32'd0);
    check("t2_stall_lw", DW'(s_stall), 32'd0);
    cpu_req = 1'b0;
    step();
    check("t2_rdata", s_cpu_rdata, 32'hDEADBEEF);
    step();
    check("t2_rdata_hold", s_cpu_rdata, 32'hDEADBEEF);

    // 3: AUX-only read.
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 12'h020;
    step();
    check("t3_gnt", DW'(s_gnt), 32'd1);
    aux_req = 1'b0;
    step();
    check("t3_rvalid", DW'(s_rvalid), 32'd1);
    check("t3_rdata", s_aux_rdata, 32'h12345678);
    step();
    check("t3_rvalid_pulse", DW'(s_rvalid), 32'd0);
    check("t3_rdata_hold", s_aux_rdata, 32'h12345678);

    // 4: continuous contention, forced AUX slot every MAX_WAIT+1 cycles.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h033;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 12'h020;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("t4_gnt", DW'(s_gnt), DW'(i % 5 == 0));
      check("t4_stall", DW'(s_stall), DW'(i % 5 == 0));
    end

    // 5: withdrawal clears the wait count.
    aux_req = 1'b0;
    step();
    aux_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("t5_pre_gnt", DW'(s_gnt), 32'd0);
    end
    aux_req = 1'b0;
    step();
    aux_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("t5_gnt", DW'(s_gnt), DW'(i == 5));
    end
    aux_req = 1'b0; cpu_req = 1'b0;
    step();

    // Randomized traffic with an AUX port obeying the hold-while-requesting rule.
    for (int n = 0; n < 400; n++) begin
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = AW'($urandom_range(0, 31));
      cpu_wdata = $urandom;
      if (aux_req && !m_gnt) begin
        if ($urandom_range(0, 9) == 0) aux_req = 1'b0;
      end else begin
        aux_req   = $urandom_range(0, 1) == 1;
        aux_we    = $urandom_range(0, 1) == 1;
        aux_addr  = AW'($urandom_range(0, 31));
        aux_wdata = $urandom;
      end
      rst_n = (n != 200);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
